// File: rtl/z3_slave_ctrl_if.sv
// Zorro III bus-side signals seen by a slave card: address/strobe/control from
// the bus master and the multiple-transfer acknowledge returned by the slave.
interface z3_slave_ctrl_if;
  logic [31:0] A;
  logic [2:0]  FC;
  logic        READ;
  logic        FCS_n;
  logic [3:0]  DS_n;
  logic        DOE;
  logic        MTCR_n;
  logic        MTACK_n;

  modport master (output A, FC, READ, FCS_n, DS_n, DOE, MTCR_n, input MTACK_n);
  modport slave  (input A, FC, READ, FCS_n, DS_n, DOE, MTCR_n, output MTACK_n);
endinterface

// File: rtl/z3_slave_ctrl.sv
// Zorro III slave cycle controller: synchronizes the bus strobes, decodes up to
// NUM_TGT address windows and sequences START/DATA/END/MULTI with timeout.
module z3_slave_ctrl #(
  parameter int NUM_TGT     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64,
  parameter int MULTI_EN    = 1
) (
  input  logic                   CLK,
  input  logic                   IORST_n,
  z3_slave_ctrl_if.slave         bus,
  input  logic [NUM_TGT-1:0]     tgt_en,
  input  logic [16*NUM_TGT-1:0]  tgt_base,
  input  logic [16*NUM_TGT-1:0]  tgt_mask,
  input  logic [NUM_TGT-1:0]     tgt_ack,
  output logic [29:0]            addr_lat,
  output logic [NUM_TGT-1:0]     tgt_sel,
  output logic                   tgt_req,
  output logic                   cyc_read,
  output logic [3:0]             byte_en,
  output logic                   dtack,
  output logic                   timeout_err
);

  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] END   = 3'd3;
  localparam logic [2:0] MULTI = 3'd4;

  logic [SYNC_STAGES-1:0]      fcs_sync_q;
  logic [SYNC_STAGES-1:0][3:0] ds_sync_q;
  logic                        fcs_s;
  logic [3:0]                  ds_s;
  logic                        ds_any, ds_none, ack_sel, to_hit;

  logic [2:0]         state_q, state_d;
  logic               miss_q;
  logic [29:0]        addr_lat_q;
  logic               cyc_read_q;
  logic [NUM_TGT-1:0] tgt_sel_q, hit_sel;
  logic               tgt_req_q;
  logic [3:0]         byte_en_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               dtack_q, timeout_err_q, mtack_n_q;
  logic               unused_bits;

  assign unused_bits = ^{bus.A[1:0], bus.FC[2]};

  always_ff @(posedge CLK or negedge IORST_n) begin
    if (!IORST_n) begin
      fcs_sync_q <= '1;
      ds_sync_q  <= '1;
    end else begin
      fcs_sync_q <= {fcs_sync_q[SYNC_STAGES-2:0], bus.FCS_n};
      ds_sync_q  <= {ds_sync_q[SYNC_STAGES-2:0], bus.DS_n};
    end
  end

  assign fcs_s   = fcs_sync_q[SYNC_STAGES-1];
  assign ds_s    = ds_sync_q[SYNC_STAGES-1];
  assign ds_any  = |(~ds_s);
  assign ds_none = &ds_s;
  assign ack_sel = |(tgt_ack & tgt_sel_q);
  assign to_hit  = (cnt_q == CNT_LAST);

  // Walk downward so the lowest matching index is the one left standing.
  always_comb begin
    hit_sel = '0;
    for (int i = NUM_TGT - 1; i >= 0; i--) begin
      if ((bus.FC[1] ^ bus.FC[0]) && tgt_en[i] &&
          (((bus.A[31:16] ^ tgt_base[16*i +: 16]) & tgt_mask[16*i +: 16]) == 16'h0)) begin
        hit_sel    = '0;
        hit_sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q != IDLE && fcs_s) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (!fcs_s && !miss_q && (|hit_sel)) state_d = START;
        START:   if (cyc_read_q || (ds_any && bus.DOE)) state_d = DATA;
        DATA:    if (ack_sel || to_hit) state_d = END;
        END:     if ((MULTI_EN != 0) && !bus.MTCR_n && ds_none) state_d = MULTI;
        MULTI:   if (ds_any && (cyc_read_q || bus.DOE)) state_d = DATA;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge IORST_n) begin
    if (!IORST_n) begin
      state_q       <= IDLE;
      miss_q        <= 1'b0;
      addr_lat_q    <= '0;
      cyc_read_q    <= 1'b0;
      tgt_sel_q     <= '0;
      tgt_req_q     <= 1'b0;
      byte_en_q     <= '0;
      cnt_q         <= '0;
      dtack_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      mtack_n_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      // A cycle that decoded to nobody is ignored until FCS_n returns high.
      miss_q  <= (state_q == IDLE) && !fcs_s && (miss_q || !(|hit_sel));
      if (state_q == IDLE && !fcs_s && !miss_q) begin
        addr_lat_q <= bus.A[31:2];
        cyc_read_q <= bus.READ;
      end else if (state_q == END && state_d == MULTI) begin
        addr_lat_q[5:0] <= bus.A[7:2];
      end
      if (state_d == IDLE)      tgt_sel_q <= '0;
      else if (state_q == IDLE) tgt_sel_q <= hit_sel;
      tgt_req_q <= (state_d == DATA) && (state_q != DATA);
      if (state_d == IDLE)                            byte_en_q <= '0;
      else if (state_d == DATA && state_q != DATA)    byte_en_q <= ~ds_s;
      cnt_q         <= (state_q == DATA && state_d == DATA) ? cnt_q + 1'b1 : '0;
      dtack_q       <= (state_d == END);
      timeout_err_q <= (state_q == DATA) && (state_d == END) && !ack_sel;
      mtack_n_q     <= !((MULTI_EN != 0) && (state_d != IDLE));
    end
  end

  assign addr_lat    = addr_lat_q;
  assign cyc_read    = cyc_read_q;
  assign tgt_sel     = tgt_sel_q;
  assign tgt_req     = tgt_req_q;
  assign byte_en     = byte_en_q;
  assign dtack       = dtack_q;
  assign timeout_err = timeout_err_q;
  assign bus.MTACK_n = mtack_n_q;

endmodule

// File: tb/tb_z3_slave_ctrl.sv
// Directed bench for z3_slave_ctrl: decode table plus hand-built read, write
// timeout, multiple-transfer and asynchronous-reset sequences.
module tb_z3_slave_ctrl;

  logic        CLK;
  logic        IORST_n;
  logic [3:0]  tgt_en;
  logic [63:0] tgt_base;
  logic [63:0] tgt_mask;
  logic [3:0]  tgt_ack;
  logic [29:0] addr_lat;
  logic [3:0]  tgt_sel;
  logic        tgt_req;
  logic        cyc_read;
  logic [3:0]  byte_en;
  logic        dtack;
  logic        timeout_err;

  z3_slave_ctrl_if bus ();

  z3_slave_ctrl #(.NUM_TGT(4), .SYNC_STAGES(2), .TIMEOUT(64), .MULTI_EN(1)) dut (
    .CLK(CLK), .IORST_n(IORST_n), .bus(bus.slave),
    .tgt_en(tgt_en), .tgt_base(tgt_base), .tgt_mask(tgt_mask), .tgt_ack(tgt_ack),
    .addr_lat(addr_lat), .tgt_sel(tgt_sel), .tgt_req(tgt_req), .cyc_read(cyc_read),
    .byte_en(byte_en), .dtack(dtack), .timeout_err(timeout_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int failures = 0;
  int req_seen = 0;
  int to_seen = 0;

  always @(posedge CLK) begin
    if (tgt_req === 1'b1) req_seen <= req_seen + 1;
    if (timeout_err === 1'b1) to_seen <= to_seen + 1;
  end

  typedef struct {
    logic [3:0]  en;
    logic [31:0] a;
    logic [2:0]  fc;
    logic [3:0]  exp_sel;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_for(input int which, input int budget, input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      step(1);
      case (which)
        0: got = (tgt_req === 1'b1);
        1: got = (dtack === 1'b1);
        2: got = (dtack === 1'b0);
        default: got = 1'b0;
      endcase
    end
    check(name, {31'd0, got}, 32'd1);
  endtask

  task automatic idle_bus();
    bus.FCS_n  = 1'b1;
    bus.DS_n   = 4'hF;
    bus.DOE    = 1'b0;
    bus.MTCR_n = 1'b1;
    tgt_ack    = 4'h0;
  endtask

  int req0, to0;

  initial begin
    IORST_n  = 1'b0;
    bus.A    = 32'h0;
    bus.FC   = 3'b001;
    bus.READ = 1'b1;
    idle_bus();
    tgt_en   = 4'hF;
    tgt_base = {16'h8000, 16'h1000, 16'h4000, 16'h1000};
    tgt_mask = {16'hFFFF, 16'hFF00, 16'hF000, 16'hF000};

    vecs[0] = '{4'b1111, 32'h4000_1234, 3'b001, 4'b0010};
    vecs[1] = '{4'b1111, 32'h10AB_0000, 3'b001, 4'b0001};
    vecs[2] = '{4'b1110, 32'h10AB_0000, 3'b001, 4'b0100};
    vecs[3] = '{4'b0000, 32'h10AB_0000, 3'b001, 4'b0000};
    vecs[4] = '{4'b1111, 32'h8000_0000, 3'b010, 4'b1000};
    vecs[5] = '{4'b1111, 32'h8001_0000, 3'b010, 4'b0000};
    vecs[6] = '{4'b1111, 32'h4000_1234, 3'b011, 4'b0000};
    vecs[7] = '{4'b1111, 32'h4000_1234, 3'b110, 4'b0010};
    vecs[8] = '{4'b1111, 32'h4FFF_0000, 3'b001, 4'b0010};
    vecs[9] = '{4'b1101, 32'h4000_0000, 3'b001, 4'b0000};

    // Reset state
    step(2);
    check("rst_addr_lat", {2'b0, addr_lat}, 32'h0);
    check("rst_tgt_sel", {28'h0, tgt_sel}, 32'h0);
    check("rst_tgt_req", {31'h0, tgt_req}, 32'h0);
    check("rst_cyc_read", {31'h0, cyc_read}, 32'h0);
    check("rst_byte_en", {28'h0, byte_en}, 32'h0);
    check("rst_dtack", {31'h0, dtack}, 32'h0);
    check("rst_mtack_n", {31'h0, bus.MTACK_n}, 32'h1);
    check("rst_timeout_err", {31'h0, timeout_err}, 32'h0);
    IORST_n = 1'b1;
    step(2);

    // Decode table: read cycles, sampled in START and first DATA cycle
    for (int v = 0; v < 10; v++) begin
      tgt_en    = vecs[v].en;
      bus.A     = vecs[v].a;
      bus.FC    = vecs[v].fc;
      bus.READ  = 1'b1;
      bus.FCS_n = 1'b0;
      step(3);
      check($sformatf("vec%0d_tgt_sel", v), {28'h0, tgt_sel}, {28'h0, vecs[v].exp_sel});
      step(1);
      check($sformatf("vec%0d_tgt_req", v), {31'h0, tgt_req}, {31'h0, (vecs[v].exp_sel != 4'h0)});
      bus.FCS_n = 1'b1;
      step(4);
      check($sformatf("vec%0d_idle_sel", v), {28'h0, tgt_sel}, 32'h0);
    end

    // Read to target 1, ack on the third DATA cycle
    tgt_en = 4'hF; bus.FC = 3'b001; bus.A = 32'h4000_1234; bus.READ = 1'b1;
    req0 = req_seen;
    bus.FCS_n = 1'b0;
    step(3);
    check("rd_tgt_sel", {28'h0, tgt_sel}, 32'h2);
    check("rd_addr_lat", {2'b0, addr_lat}, 32'h1000_048D);
    check("rd_cyc_read", {31'h0, cyc_read}, 32'h1);
    check("rd_mtack_start", {31'h0, bus.MTACK_n}, 32'h0);
    step(1);
    check("rd_tgt_req", {31'h0, tgt_req}, 32'h1);
    step(1);
    check("rd_tgt_req_drop", {31'h0, tgt_req}, 32'h0);
    step(1);
    check("rd_dtack_pre", {31'h0, dtack}, 32'h0);
    tgt_ack = 4'b0010;
    step(1);
    check("rd_dtack", {31'h0, dtack}, 32'h1);
    step(2);
    check("rd_dtack_hold", {31'h0, dtack}, 32'h1);
    bus.FCS_n = 1'b1;
    step(2);
    check("rd_dtack_sync", {31'h0, dtack}, 32'h1);
    step(1);
    check("rd_end_dtack", {31'h0, dtack}, 32'h0);
    check("rd_end_sel", {28'h0, tgt_sel}, 32'h0);
    check("rd_end_mtack", {31'h0, bus.MTACK_n}, 32'h1);
    check("rd_req_count", req_seen - req0, 32'd1);
    tgt_ack = 4'h0;
    step(2);

    // Write with timeout; only non-selected targets ack
    bus.A = 32'h4000_0000; bus.READ = 1'b0; bus.DOE = 1'b1; bus.DS_n = 4'b1100;
    tgt_ack = 4'b1101;
    to0 = to_seen;
    bus.FCS_n = 1'b0;
    step(4);
    check("wr_tgt_req", {31'h0, tgt_req}, 32'h1);
    check("wr_byte_en", {28'h0, byte_en}, 32'h3);
    step(63);
    check("wr_to_pre", {31'h0, timeout_err}, 32'h0);
    check("wr_dtack_pre", {31'h0, dtack}, 32'h0);
    step(1);
    check("wr_timeout_err", {31'h0, timeout_err}, 32'h1);
    check("wr_dtack", {31'h0, dtack}, 32'h1);
    step(1);
    check("wr_to_drop", {31'h0, timeout_err}, 32'h0);
    check("wr_dtack_hold", {31'h0, dtack}, 32'h1);
    check("wr_to_count", to_seen - to0, 32'd1);
    idle_bus();
    step(4);
    check("wr_idle_dtack", {31'h0, dtack}, 32'h0);

    // Write held in START until DOE rises
    req0 = req_seen;
    bus.A = 32'h4000_0000; bus.READ = 1'b0; bus.DOE = 1'b0; bus.DS_n = 4'h0;
    bus.FCS_n = 1'b0;
    step(6);
    check("doe_hold_sel", {28'h0, tgt_sel}, 32'h2);
    check("doe_hold_noreq", req_seen - req0, 32'd0);
    bus.DOE = 1'b1;
    step(1);
    check("doe_tgt_req", {31'h0, tgt_req}, 32'h1);
    idle_bus();
    step(4);

    // Multiple transfer: three write beats at A[7:2] = 0,1,2
    req0 = req_seen;
    bus.READ = 1'b0; bus.DOE = 1'b1; bus.MTCR_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.A = 32'h4000_0000 | (k << 2);
      if (k == 0) begin
        bus.DS_n  = 4'h0;
        bus.FCS_n = 1'b0;
      end else begin
        bus.DS_n = 4'hF;
        wait_for(2, 10, $sformatf("mt%0d_dtack_low", k));
        check($sformatf("mt%0d_gap_dtack", k), {31'h0, dtack}, 32'h0);
        check($sformatf("mt%0d_gap_mtack", k), {31'h0, bus.MTACK_n}, 32'h0);
        bus.DS_n = 4'h0;
      end
      wait_for(0, 10, $sformatf("mt%0d_tgt_req", k));
      check($sformatf("mt%0d_addr", k), {26'h0, addr_lat[5:0]}, k);
      check($sformatf("mt%0d_mtack", k), {31'h0, bus.MTACK_n}, 32'h0);
      tgt_ack = 4'b0010;
      wait_for(1, 10, $sformatf("mt%0d_dtack", k));
      tgt_ack = 4'h0;
    end
    check("mt_req_count", req_seen - req0, 32'd3);
    idle_bus();
    step(4);
    check("mt_idle_mtack", {31'h0, bus.MTACK_n}, 32'h1);

    // Asynchronous reset in END, then restart with FCS_n still low
    bus.A = 32'h4000_1234; bus.READ = 1'b1;
    tgt_ack = 4'b0010;
    bus.FCS_n = 1'b0;
    step(5);
    check("ar_dtack_end", {31'h0, dtack}, 32'h1);
    #3;
    IORST_n = 1'b0;
    #1;
    check("ar_dtack", {31'h0, dtack}, 32'h0);
    check("ar_tgt_sel", {28'h0, tgt_sel}, 32'h0);
    check("ar_mtack", {31'h0, bus.MTACK_n}, 32'h1);
    tgt_ack = 4'h0;
    #2;
    IORST_n = 1'b1;
    wait_for(0, 8, "ar_restart_req");
    check("ar_restart_sel", {28'h0, tgt_sel}, 32'h2);
    idle_bus();
    step(4);
    check("ar_idle_sel", {28'h0, tgt_sel}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
